// File: rtl/param_interval_timer.sv
// Programmable down-counting interval timer with a 16-bit register interface.
// It provides one-shot and continuous modes, snapshot capture, and a saturating timeout counter.
module param_interval_timer #(
    parameter int unsigned WIDTH          = 26,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [WIDTH-1:0] RESET_PERIOD = DEFAULT_PERIOD[WIDTH-1:0];
    localparam int unsigned      HI_BITS      = WIDTH - 16;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;
    localparam logic [2:0] ADDR_TOCNT    = 3'd6;

    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] snapshot;
    logic [15:0]      tocnt;
    logic             run;
    logic             to;
    logic             ito;
    logic             cont;
    logic             force_reload;

    logic        wr;
    logic        wr_status;
    logic        wr_control;
    logic        wr_period_l;
    logic        wr_period_h;
    logic        wr_snap;
    logic        wr_tocnt;
    logic        start;
    logic        stop;
    logic        timeout;
    logic [31:0] period_ext;
    logic [31:0] snap_ext;
    logic [15:0] read_mux;

    always_comb begin
        wr          = chipselect && !write_n;
        wr_status   = wr && (address == ADDR_STATUS);
        wr_control  = wr && (address == ADDR_CONTROL);
        wr_period_l = wr && (address == ADDR_PERIOD_L);
        wr_period_h = wr && (address == ADDR_PERIOD_H);
        wr_snap     = wr && ((address == ADDR_SNAP_L) || (address == ADDR_SNAP_H));
        wr_tocnt    = wr && (address == ADDR_TOCNT);
        start       = wr_control && writedata[2];
        stop        = wr_control && writedata[3];
        // The reload cycle after a period write never counts as an expiry.
        timeout     = run && (counter == '0) && !force_reload;

        period_ext             = '0;
        period_ext[WIDTH-1:0]  = period;
        snap_ext               = '0;
        snap_ext[WIDTH-1:0]    = snapshot;

        read_mux = '0;
        case (address)
            ADDR_STATUS:   read_mux = {14'd0, run, to};
            ADDR_CONTROL:  read_mux = {14'd0, cont, ito};
            ADDR_PERIOD_L: read_mux = period_ext[15:0];
            ADDR_PERIOD_H: read_mux = period_ext[31:16];
            ADDR_SNAP_L:   read_mux = snap_ext[15:0];
            ADDR_SNAP_H:   read_mux = snap_ext[31:16];
            ADDR_TOCNT:    read_mux = tocnt;
            default:       read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period       <= RESET_PERIOD;
            counter      <= RESET_PERIOD;
            snapshot     <= '0;
            tocnt        <= '0;
            run          <= 1'b0;
            to           <= 1'b0;
            ito          <= 1'b0;
            cont         <= 1'b0;
            force_reload <= 1'b0;
            readdata     <= '0;
        end else begin
            readdata     <= read_mux;
            force_reload <= wr_period_l || wr_period_h;

            if (wr_period_l) period[15:0]       <= writedata;
            if (wr_period_h) period[WIDTH-1:16] <= writedata[HI_BITS-1:0];

            if (wr_control) begin
                ito  <= writedata[0];
                cont <= writedata[1];
            end

            if (force_reload)
                counter <= period;
            else if (run)
                counter <= (counter == '0) ? period : counter - WIDTH'(1);

            if (start)
                run <= 1'b1;
            else if (stop || force_reload || (timeout && !cont))
                run <= 1'b0;

            if (timeout)
                to <= 1'b1;
            else if (wr_status)
                to <= 1'b0;

            // A clear coinciding with an expiry leaves exactly that one event counted.
            if (timeout)
                tocnt <= wr_tocnt ? 16'd1 : ((tocnt == 16'hFFFF) ? tocnt : tocnt + 16'd1);
            else if (wr_tocnt)
                tocnt <= '0;

            if (wr_snap) snapshot <= counter;
        end
    end

    assign irq = to && ito;

endmodule

// File: tb/tb_param_interval_timer.sv
// Self-checking bench for param_interval_timer: directed scenarios with arithmetic expectations
// plus a randomized bus run checked against a behavioural register model.
module tb_param_interval_timer;

    localparam int unsigned WMASK   = 32'h03FF_FFFF;
    localparam int unsigned DEF_PER = 32'd49999999;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int unsigned m_period, m_cnt, m_snap, m_tocnt, m_rd;
    bit          m_run, m_to, m_ito, m_cont, m_fr, m_irq;

    param_interval_timer #(.WIDTH(26), .DEFAULT_PERIOD(32'd49999999)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_period = DEF_PER;
        m_cnt    = DEF_PER;
        m_snap   = 0;
        m_tocnt  = 0;
        m_rd     = 0;
        m_run    = 0;
        m_to     = 0;
        m_ito    = 0;
        m_cont   = 0;
        m_fr     = 0;
        m_irq    = 0;
    endtask

    task automatic model_edge(input bit cs, input bit wn, input int unsigned a, input int unsigned d);
        bit          wr, expire, start, stop;
        int unsigned n_period, n_cnt, n_tocnt;
        bit          n_run, n_to;
        wr     = cs && !wn;
        expire = m_run && (m_cnt == 0) && !m_fr;
        start  = wr && a == 1 && d[2];
        stop   = wr && a == 1 && d[3];

        case (a)
            0: m_rd = (int'(m_run) << 1) | int'(m_to);
            1: m_rd = (int'(m_cont) << 1) | int'(m_ito);
            2: m_rd = m_period % 65536;
            3: m_rd = m_period / 65536;
            4: m_rd = m_snap % 65536;
            5: m_rd = m_snap / 65536;
            6: m_rd = m_tocnt;
            default: m_rd = 0;
        endcase

        n_period = m_period;
        if (wr && a == 2) n_period = (m_period / 65536) * 65536 + d;
        if (wr && a == 3) n_period = ((d * 65536) + (m_period % 65536)) & WMASK;

        n_cnt = m_cnt;
        if (m_fr)        n_cnt = m_period;
        else if (m_run)  n_cnt = expire ? m_period : m_cnt - 1;

        n_run = m_run;
        if (expire && !m_cont) n_run = 0;
        if (m_fr || stop)      n_run = 0;
        if (start)             n_run = 1;

        n_to = (m_to && !(wr && a == 0)) || expire;

        n_tocnt = (wr && a == 6) ? 0 : m_tocnt;
        if (expire) n_tocnt = (n_tocnt + 1 > 65535) ? 65535 : n_tocnt + 1;

        if (wr && (a == 4 || a == 5)) m_snap = m_cnt;
        if (wr && a == 1) begin
            m_ito  = d[0];
            m_cont = d[1];
        end
        m_fr     = wr && (a == 2 || a == 3);
        m_period = n_period;
        m_cnt    = n_cnt;
        m_run    = n_run;
        m_to     = n_to;
        m_tocnt  = n_tocnt;
        m_irq    = m_to && m_ito;
    endtask

    task automatic bus(input bit cs, input bit wn, input logic [2:0] a, input logic [15:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_edge(cs, wn, int'(a), int'(d));
        #1;
    endtask

    task automatic idle_cycle(input logic [2:0] a);
        bus(1'b0, 1'b1, a, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 16'h0;
        @(posedge clk);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_tab [8];
        exp_tab = '{16'h0, 16'h0, 16'hF07F, 16'h02FA, 16'h0, 16'h0, 16'h0, 16'h0};
        apply_reset();
        checks++;
        if (readdata !== 16'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b expected 0000/0", readdata, irq);
        end
        for (int a = 0; a < 8; a++) begin
            idle_cycle(3'(a));
            checks++;
            if (readdata !== exp_tab[a]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, readdata, exp_tab[a]);
            end
        end
    endtask

    task automatic test_continuous();
        apply_reset();
        wr(3'd2, 16'h0004);
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0007);
        for (int k = 1; k <= 15; k++) begin
            idle_cycle(3'd6);
            checks++;
            if (irq !== (k >= 5)) begin
                errors++;
                $display("FAIL cont_irq_k%0d: got %b expected %b", k, irq, (k >= 5));
            end
            checks++;
            if (readdata !== 16'((k - 1) / 5)) begin
                errors++;
                $display("FAIL cont_tocnt_k%0d: got %h expected %h", k, readdata, 16'((k - 1) / 5));
            end
        end
        idle_cycle(3'd6);
        checks++;
        if (readdata !== 16'd3) begin
            errors++;
            $display("FAIL cont_tocnt_final: got %h expected 0003", readdata);
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] exp_st;
        apply_reset();
        wr(3'd2, 16'h0002);
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0005);
        for (int k = 1; k <= 6; k++) begin
            idle_cycle(3'd0);
            exp_st = ((k - 1) < 3) ? 16'h0002 : 16'h0001;
            checks++;
            if (readdata !== exp_st || irq !== (k >= 3)) begin
                errors++;
                $display("FAIL oneshot_k%0d: status=%h irq=%b expected %h/%b", k, readdata, irq, exp_st, (k >= 3));
            end
        end
        wr(3'd4, 16'h0);
        idle_cycle(3'd4);
        checks++;
        if (readdata !== 16'h0002) begin
            errors++;
            $display("FAIL oneshot_held_count: got %h expected 0002", readdata);
        end
        wr(3'd0, 16'h0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_snapshot_rewrite();
        apply_reset();
        wr(3'd2, 16'h2345);
        wr(3'd3, 16'h0001);
        wr(3'd1, 16'h0006);
        repeat (16'h2345) idle_cycle(3'd0);
        wr(3'd4, 16'h0);
        idle_cycle(3'd4);
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("FAIL snap_l: got %h expected 0000", readdata);
        end
        idle_cycle(3'd5);
        checks++;
        if (readdata !== 16'h0001) begin
            errors++;
            $display("FAIL snap_h: got %h expected 0001", readdata);
        end
        wr(3'd2, 16'h0100);
        idle_cycle(3'd0);
        idle_cycle(3'd0);
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("FAIL rewrite_status: got %h expected 0000", readdata);
        end
        repeat (3) idle_cycle(3'd0);
        wr(3'd5, 16'h0);
        idle_cycle(3'd4);
        checks++;
        if (readdata !== 16'h0100) begin
            errors++;
            $display("FAIL rewrite_cnt_l: got %h expected 0100", readdata);
        end
        idle_cycle(3'd5);
        checks++;
        if (readdata !== 16'h0001) begin
            errors++;
            $display("FAIL rewrite_cnt_h: got %h expected 0001", readdata);
        end
    endtask

    task automatic test_collisions();
        // status write on the expiry cycle
        apply_reset();
        wr(3'd2, 16'h0004);
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0007);
        repeat (4) idle_cycle(3'd0);
        wr(3'd0, 16'h0);
        idle_cycle(3'd0);
        checks++;
        if (readdata !== 16'h0003 || irq !== 1'b1) begin
            errors++;
            $display("FAIL coll_to_set: status=%h irq=%b expected 0003/1", readdata, irq);
        end
        // start and stop together
        apply_reset();
        wr(3'd1, 16'h000C);
        idle_cycle(3'd0);
        checks++;
        if (readdata !== 16'h0002) begin
            errors++;
            $display("FAIL coll_start_stop: got %h expected 0002", readdata);
        end
        wr(3'd1, 16'h0008);
        wr(3'd1, 16'h000B);
        idle_cycle(3'd0);
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("FAIL stop_idle_status: got %h expected 0000", readdata);
        end
        idle_cycle(3'd1);
        checks++;
        if (readdata !== 16'h0003) begin
            errors++;
            $display("FAIL stop_ctrl_stored: got %h expected 0003", readdata);
        end
        // TOCNT saturation and clear-versus-expiry
        apply_reset();
        wr(3'd2, 16'h0000);
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0006);
        repeat (65540) idle_cycle(3'd6);
        checks++;
        if (readdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL tocnt_sat: got %h expected ffff", readdata);
        end
        idle_cycle(3'd6);
        idle_cycle(3'd6);
        checks++;
        if (readdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL tocnt_sat_hold: got %h expected ffff", readdata);
        end
        wr(3'd6, 16'h0);
        idle_cycle(3'd6);
        checks++;
        if (readdata !== 16'h0001) begin
            errors++;
            $display("FAIL tocnt_clear_coll: got %h expected 0001", readdata);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] exp_tab [8];
        exp_tab = '{16'h0, 16'h0, 16'hF07F, 16'h02FA, 16'h0, 16'h0, 16'h0, 16'h0};
        apply_reset();
        wr(3'd2, 16'h0004);
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0007);
        repeat (7) idle_cycle(3'd0);
        apply_reset();
        checks++;
        if (readdata !== 16'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midrun_outputs: readdata=%h irq=%b expected 0000/0", readdata, irq);
        end
        for (int a = 0; a < 8; a++) begin
            idle_cycle(3'(a));
            checks++;
            if (readdata !== exp_tab[a]) begin
                errors++;
                $display("FAIL midrun_reg%0d: got %h expected %h", a, readdata, exp_tab[a]);
            end
        end
        repeat (10) idle_cycle(3'd0);
        wr(3'd4, 16'h0);
        idle_cycle(3'd0);
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_idle_status: got %h expected 0000", readdata);
        end
        idle_cycle(3'd4);
        checks++;
        if (readdata !== 16'hF07F) begin
            errors++;
            $display("FAIL midrun_held_cnt: got %h expected f07f", readdata);
        end
    endtask

    task automatic test_random();
        logic [2:0]  a;
        logic [15:0] d;
        bit          cs, wn;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            a  = 3'($urandom_range(0, 7));
            wn = ($urandom_range(0, 9) >= 4);
            cs = ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            if (a == 3'd2) d = 16'($urandom_range(0, 12));
            if (a == 3'd3) d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
            if (a == 3'd1 && $urandom_range(0, 1) == 0) d = 16'($urandom_range(0, 15));
            bus(cs, wn, a, d);
            checks++;
            if (readdata !== 16'(m_rd)) begin
                errors++;
                $display("FAIL rand_read_%0d: addr=%0d got %h expected %h", i, a, readdata, 16'(m_rd));
            end
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL rand_irq_%0d: got %b expected %b", i, irq, m_irq);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 16'h0;
        model_reset();
        test_reset();
        test_continuous();
        test_oneshot();
        test_snapshot_rewrite();
        test_collisions();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_interval_timer.md
PARAM_INTERVAL_TIMER -- requirements
Module: param_interval_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 26, meaning the counter/period width; legal range 17..32.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 49999999 (26'h2FAF07F), meaning the period loaded at reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; reset is synchronous and active-low.
REQ-005 SHALL have port address, input, 3, register select.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe; write = chipselect && !write_n.
REQ-008 SHALL have port writedata, input, 16, write data.
REQ-009 SHALL have port readdata, output, 16, registered read data.
REQ-010 SHALL have port irq, output, 1, level interrupt = TO && ITO.

Function
REQ-011 SHALL use this register map:
- 0 STATUS: bit0 TO, bit1 RUN, read-only; any write clears TO.
- 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. START and STOP are write strobes only and read 0.
- 2/3 PERIOD_L/H: period bits [15:0] and [WIDTH-1:16]; read back.
- 4/5 SNAP_L/H: a write to either latches the counter; a read returns the latched value.
- 6 TOCNT: 16-bit saturating timeout count; any write clears it.
- 7: reads 0; writes ignored.
REQ-012 SHALL return readdata one cycle after the address is presented (mux registered unconditionally). Unused and out-of-width bits SHALL read 0.
REQ-013 SHALL ignore PERIOD_H writedata bits at or above WIDTH-16.
REQ-014 SHALL, while RUN=1, decrement the counter by 1 per cycle when it is nonzero.
REQ-015 SHALL, while RUN=1 and the counter is 0, raise a one-cycle timeout event, reload the period, and clear RUN when CONT=0. Period P SHALL therefore yield one timeout every P+1 cycles.
REQ-016 SHALL hold the counter while RUN=0; no timeout events are raised.
REQ-017 SHALL set force_reload for one cycle after any PERIOD_L/H write. In that cycle it SHALL load the counter with the new period, clear RUN, and suppress the timeout event.
REQ-018 SHALL give start priority when START is set in the same cycle as STOP, force_reload, or a one-shot expiry; RUN=1 results.
REQ-019 SHALL give the set priority over the clear when a timeout event and a STATUS write coincide; TO ends at 1.
REQ-020 SHALL count up TOCNT on each timeout event and saturate it at 0xFFFF. When a TOCNT write coincides with a timeout event, TOCNT SHALL end at 1.
REQ-021 SHALL latch the counter value present in the write cycle on a snapshot; the latched value is zero-extended to 32 bits.
REQ-022 SHALL clear RUN and take no other action on a STOP while RUN=0.
REQ-023 SHALL store CONT/ITO on every CONTROL write, including writes carrying START or STOP.

Reset
REQ-024 SHALL, on the clk edge with reset_n=0, set:
- period and counter to DEFAULT_PERIOD
- RUN, TO, ITO, CONT, force_reload to 0
- TOCNT, snapshot, readdata to 0
- irq to 0
REQ-025 SHALL abort any count on reset asserted mid-run. After release the timer SHALL stay idle until START.
REQ-026 SHALL NOT act on the asynchronous state of reset_n between edges.

Verification
REQ-027 Continuous mode: period 4 (write 2=0x0004, 3=0x0000), CONTROL=0x0007 -> first timeout 5 cycles after the START write cycle, then every 5 cycles. irq=1 from the first timeout; TOCNT=3 after 15 cycles.
REQ-028 One-shot mode: period 2, CONTROL=0x0005 -> one timeout, then RUN=0. Counter holds 2, STATUS reads 0x0001, irq=1. A STATUS write -> irq=0 next cycle.
REQ-029 Snapshot and period rewrite: period 0x12345 (WIDTH=26), running; SNAP_L write on the cycle the counter is 0x10000 -> SNAP_L/H read 0x0000/0x0001. A PERIOD_L write mid-run -> RUN=0 and counter = new period.
REQ-030 Collisions:
- STATUS write on the timeout cycle -> TO=1.
- START+STOP (CONTROL=0x000C) -> RUN=1.
- TOCNT at 0xFFFF plus a timeout -> stays 0xFFFF.
REQ-031 Reset mid-run: reset_n=0 for 1 cycle during a count -> all registers at reset values; readdata=0; address 2/3 read DEFAULT_PERIOD halves 0xF07F/0x02FA.
